// File: rtl/qbit_sense_ctrl.sv
// Read-side controller for one differential qbit cell: precharge, settle, sense,
// restore, then acknowledge. All outputs come straight from flops.
module qbit_sense_ctrl #(
  parameter int unsigned PRECHARGE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES    = 3,
  parameter int unsigned RESTORE_CYCLES   = 2
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       ReadReq,
  input  logic       SenseN,
  input  logic       SenseS,
  output logic       ReadAck,
  output logic       ReadData,
  output logic       ReadErr,
  output logic [7:0] ErrCount,
  output logic       PrechargeEn,
  output logic       SelectEn,
  output logic       SenseEn,
  output logic       RestoreEn,
  output logic       RestoreN,
  output logic       RestoreS
);

  // Phase lengths must fit the shared 8-bit down-counter and be non-zero.
  if (PRECHARGE_CYCLES < 1 || PRECHARGE_CYCLES > 255 ||
      SETTLE_CYCLES < 1    || SETTLE_CYCLES > 255    ||
      RESTORE_CYCLES < 1   || RESTORE_CYCLES > 255) begin : g_bad_cfg
    $error("qbit_sense_ctrl: phase cycle parameters must be in 1..255");
  end

  localparam logic [7:0] PreLoad = 8'(PRECHARGE_CYCLES - 1);
  localparam logic [7:0] SetLoad = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] ResLoad = 8'(RESTORE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPrecharge,
    StSettle,
    StSense,
    StRestore,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic       read_data_d, read_err_d;
  logic [7:0] err_cnt_d;
  logic       ack_d, pre_d, sel_d, sense_d, rest_en_d, rest_n_d, rest_s_d;

  // Next-state, counter and result update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = ReadData;
    read_err_d  = ReadErr;
    err_cnt_d   = ErrCount;
    case (state_q)
      StIdle: begin
        if (ReadReq) begin
          state_d = StPrecharge;
          cnt_d   = PreLoad;
        end
      end
      StPrecharge: begin
        if (cnt_q == 8'd0) begin
          state_d = StSettle;
          cnt_d   = SetLoad;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          state_d = StSense;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSense: begin
        if (SenseN != SenseS) begin
          read_data_d = SenseN;
          read_err_d  = 1'b0;
          state_d     = StRestore;
          cnt_d       = ResLoad;
        end else begin
          // Equal rails: no valid bit to write back, so skip restore.
          read_data_d = 1'b0;
          read_err_d  = 1'b1;
          if (ErrCount != 8'hFF) begin
            err_cnt_d = ErrCount + 8'd1;
          end
          state_d = StDone;
        end
      end
      StRestore: begin
        if (cnt_q == 8'd0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so they register cleanly.
  always_comb begin
    pre_d     = (state_d == StPrecharge);
    sel_d     = (state_d == StSettle) || (state_d == StSense) || (state_d == StRestore);
    sense_d   = (state_d == StSense);
    rest_en_d = (state_d == StRestore);
    rest_n_d  = rest_en_d & read_data_d;
    rest_s_d  = rest_en_d & ~read_data_d;
    ack_d     = (state_d == StDone);
  end

  // State, counter and registered outputs; reset abandons any read in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      ReadAck     <= 1'b0;
      ReadData    <= 1'b0;
      ReadErr     <= 1'b0;
      ErrCount    <= 8'd0;
      PrechargeEn <= 1'b0;
      SelectEn    <= 1'b0;
      SenseEn     <= 1'b0;
      RestoreEn   <= 1'b0;
      RestoreN    <= 1'b0;
      RestoreS    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ReadAck     <= ack_d;
      ReadData    <= read_data_d;
      ReadErr     <= read_err_d;
      ErrCount    <= err_cnt_d;
      PrechargeEn <= pre_d;
      SelectEn    <= sel_d;
      SenseEn     <= sense_d;
      RestoreEn   <= rest_en_d;
      RestoreN    <= rest_n_d;
      RestoreS    <= rest_s_d;
    end
  end

endmodule

// File: tb/tb_qbit_sense_ctrl.sv
// Randomized bench for qbit_sense_ctrl against a per-read timeline model,
// plus a directed short-parameter read on a second instance.
module tb_qbit_sense_ctrl;

  localparam int P = 2;
  localparam int S = 3;
  localparam int R = 2;

  logic       Clk = 1'b0;
  logic       Rst, ReadReq, SenseN, SenseS;
  logic       ReadAck, ReadData, ReadErr;
  logic [7:0] ErrCount;
  logic       PrechargeEn, SelectEn, SenseEn, RestoreEn, RestoreN, RestoreS;

  logic       req2;
  logic       ack2, data2, err2;
  logic [7:0] errcnt2;
  logic       pre2, sel2, sense2, rest2, rn2, rs2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 Clk = ~Clk;

  qbit_sense_ctrl #(
    .PRECHARGE_CYCLES(P),
    .SETTLE_CYCLES   (S),
    .RESTORE_CYCLES  (R)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .ReadReq    (ReadReq),
    .SenseN     (SenseN),
    .SenseS     (SenseS),
    .ReadAck    (ReadAck),
    .ReadData   (ReadData),
    .ReadErr    (ReadErr),
    .ErrCount   (ErrCount),
    .PrechargeEn(PrechargeEn),
    .SelectEn   (SelectEn),
    .SenseEn    (SenseEn),
    .RestoreEn  (RestoreEn),
    .RestoreN   (RestoreN),
    .RestoreS   (RestoreS)
  );

  qbit_sense_ctrl #(
    .PRECHARGE_CYCLES(1),
    .SETTLE_CYCLES   (1),
    .RESTORE_CYCLES  (1)
  ) dut_short (
    .Clk        (Clk),
    .Rst        (Rst),
    .ReadReq    (req2),
    .SenseN     (SenseN),
    .SenseS     (SenseS),
    .ReadAck    (ack2),
    .ReadData   (data2),
    .ReadErr    (err2),
    .ErrCount   (errcnt2),
    .PrechargeEn(pre2),
    .SelectEn   (sel2),
    .SenseEn    (sense2),
    .RestoreEn  (rest2),
    .RestoreN   (rn2),
    .RestoreS   (rs2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a read is a timeline indexed by cycles since acceptance (k = 1 is the
  // first precharge cycle); its length is fixed once the sense result is known.
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_len  = 0;
  bit m_data = 1'b0;
  bit m_err  = 1'b0;
  int m_cnt  = 0;

  task automatic model_edge();
    if (Rst) begin
      m_busy = 1'b0;
      m_data = 1'b0;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else if (!m_busy) begin
      if (ReadReq) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_len  = P + S + R + 2;
      end
    end else begin
      if (m_k == P + S + 1) begin
        if (SenseN != SenseS) begin
          m_data = SenseN;
          m_err  = 1'b0;
          m_len  = P + S + R + 2;
        end else begin
          m_data = 1'b0;
          m_err  = 1'b1;
          m_len  = P + S + 2;
          if (m_cnt < 255) m_cnt++;
        end
      end
      if (m_k == m_len) m_busy = 1'b0;
      else m_k++;
    end
  endtask

  task automatic compare();
    bit e_pre, e_sel, e_sense, e_rest, e_ack;
    e_pre   = m_busy && (m_k <= P);
    e_sense = m_busy && (m_k == P + S + 1);
    e_rest  = m_busy && (m_k > P + S + 1) && (m_k < m_len);
    e_sel   = (m_busy && (m_k > P) && (m_k <= P + S + 1)) || e_rest;
    e_ack   = m_busy && (m_k == m_len);
    check_eq("precharge_en", 32'(PrechargeEn), 32'(e_pre));
    check_eq("select_en", 32'(SelectEn), 32'(e_sel));
    check_eq("sense_en", 32'(SenseEn), 32'(e_sense));
    check_eq("restore_en", 32'(RestoreEn), 32'(e_rest));
    check_eq("restore_n", 32'(RestoreN), 32'(e_rest & m_data));
    check_eq("restore_s", 32'(RestoreS), 32'(e_rest & ~m_data));
    check_eq("read_ack", 32'(ReadAck), 32'(e_ack));
    check_eq("read_data", 32'(ReadData), 32'(m_data));
    check_eq("read_err", 32'(ReadErr), 32'(m_err));
    check_eq("err_count", 32'(ErrCount), 32'(m_cnt));
    check_eq("pre_sel_overlap", 32'(PrechargeEn & SelectEn), 32'd0);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    compare();
  endtask

  initial begin
    bit b;
    Rst     = 1'b1;
    ReadReq = 1'b0;
    SenseN  = 1'b0;
    SenseS  = 1'b0;
    req2    = 1'b0;
    step();
    step();
    Rst = 1'b0;

    // Mixed traffic with occasional resets landing mid-read.
    for (int i = 0; i < 600; i++) begin
      Rst     = ($urandom_range(0, 99) == 0);
      ReadReq = ($urandom_range(0, 9) < 7);
      SenseN  = 1'($urandom);
      SenseS  = 1'($urandom);
      step();
    end

    // Back-to-back errored reads to drive the error counter into saturation.
    Rst = 1'b0;
    for (int i = 0; i < 2300; i++) begin
      ReadReq = 1'b1;
      b       = 1'($urandom);
      SenseN  = b;
      SenseS  = b;
      step();
    end
    check_eq("err_count_saturated", 32'(ErrCount), 32'd255);

    for (int i = 0; i < 400; i++) begin
      Rst     = ($urandom_range(0, 49) == 0);
      ReadReq = ($urandom_range(0, 1) == 1);
      SenseN  = 1'($urandom);
      SenseS  = 1'($urandom);
      step();
    end

    // Single-cycle phases, request dropped after acceptance: ack at cycle 5.
    Rst     = 1'b0;
    ReadReq = 1'b0;
    SenseN  = 1'b1;
    SenseS  = 1'b0;
    for (int i = 0; i < 12; i++) step();
    req2 = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      req2 = 1'b0;
      check_eq("short_pre", 32'(pre2), 32'(c == 1));
      check_eq("short_sel", 32'(sel2), 32'(c >= 2 && c <= 4));
      check_eq("short_sense", 32'(sense2), 32'(c == 3));
      check_eq("short_restore", 32'(rest2), 32'(c == 4));
      check_eq("short_rn", 32'(rn2), 32'(c == 4));
      check_eq("short_rs", 32'(rs2), 32'd0);
      check_eq("short_ack", 32'(ack2), 32'(c == 5));
      if (c >= 4) begin
        check_eq("short_data", 32'(data2), 32'd1);
        check_eq("short_err", 32'(err2), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
